// File: rtl/hv_rac_arb_if.sv
// hv_rac_arb_if: requester and rac-side bundle for the hv rac port arbiter.
`timescale 1ns/1ps
interface hv_rac_arb_if #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned REG_AW    = 7,
    parameter int unsigned REG_DW    = 8,
    parameter int unsigned REG_CRC_W = 8
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_wr;
    logic [NUM_REQ*REG_AW-1:0] i_addr;
    logic [NUM_REQ*REG_DW-1:0] i_wdata;
    logic [NUM_REQ-1:0]        o_ack;
    logic [NUM_REQ-1:0]        o_tmo_err;
    logic [REG_DW-1:0]         o_rdata;
    logic [REG_CRC_W-1:0]      o_rcrc;
    logic                      o_busy;
    logic [IDW-1:0]            o_gnt_id;
    logic                      o_rac_rd_req;
    logic                      o_rac_wr_req;
    logic [REG_AW-1:0]         o_rac_addr;
    logic [REG_DW-1:0]         o_rac_wdata;
    logic                      i_rac_ack;
    logic [REG_DW-1:0]         i_rac_rdata;
    logic [REG_CRC_W-1:0]      i_rac_crc;

    // Arbiter view
    modport slave (
        input  i_req, i_wr, i_addr, i_wdata, i_rac_ack, i_rac_rdata, i_rac_crc,
        output o_ack, o_tmo_err, o_rdata, o_rcrc, o_busy, o_gnt_id,
               o_rac_rd_req, o_rac_wr_req, o_rac_addr, o_rac_wdata
    );

    // Requesters plus rac view
    modport master (
        output i_req, i_wr, i_addr, i_wdata, i_rac_ack, i_rac_rdata, i_rac_crc,
        input  o_ack, o_tmo_err, o_rdata, o_rcrc, o_busy, o_gnt_id,
               o_rac_rd_req, o_rac_wr_req, o_rac_addr, o_rac_wdata
    );
endinterface

// File: rtl/hv_rac_arb.sv
// hv_rac_arb: grants one of NUM_REQ requesters the single hv rac port, runs the
// access until rac ack or ack timeout, and returns rdata/crc to the winner.
// Optional macro HV_RAC_ARB_RR_EN selects round-robin arbitration; without it
// the lowest requesting index wins.
`timescale 1ns/1ps
module hv_rac_arb #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned REG_AW     = 7,
    parameter int unsigned REG_DW     = 8,
    parameter int unsigned REG_CRC_W  = 8,
    parameter int unsigned ACK_TMO_TH = 16,
    parameter int unsigned TMO_CNT_W  = 5
) (
    input logic         i_clk,
    input logic         i_rst,
    hv_rac_arb_if.slave bus
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [TMO_CNT_W-1:0] cnt, cnt_nxt;
    logic [NUM_REQ-1:0]   ack_q, ack_nxt;
    logic [NUM_REQ-1:0]   tmo_q, tmo_nxt;
    logic [REG_DW-1:0]    rdata_q, rdata_nxt;
    logic [REG_CRC_W-1:0] rcrc_q, rcrc_nxt;
    logic                 busy_q, busy_nxt;
    logic [IDW-1:0]       gnt_q, gnt_nxt;
    logic                 rd_q, rd_nxt;
    logic                 wr_q, wr_nxt;
    logic [REG_AW-1:0]    addr_q, addr_nxt;
    logic [REG_DW-1:0]    wdata_q, wdata_nxt;

    logic                 win_vld;
    logic [IDW-1:0]       win_id;
    logic                 sel_wr;
    logic [REG_AW-1:0]    sel_addr;
    logic [REG_DW-1:0]    sel_wdata;
    logic [NUM_REQ-1:0]   gnt_onehot;

`ifdef HV_RAC_ARB_RR_EN
    logic [IDW-1:0]       ptr, ptr_nxt;

    // Round-robin winner: search starts one past the last grantee
    always_comb begin
        int unsigned idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && bus.i_req[IDW'(idx)]) begin
                win_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end
`else
    // Fixed-priority winner: lowest requesting index
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && bus.i_req[k]) begin
                win_vld = 1'b1;
                win_id  = IDW'(k);
            end
        end
    end
`endif

    // Pick the winner's command fields out of the packed request buses
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_id == IDW'(k)) begin
                sel_wr    = bus.i_wr[k];
                sel_addr  = bus.i_addr[k*REG_AW +: REG_AW];
                sel_wdata = bus.i_wdata[k*REG_DW +: REG_DW];
            end
        end
    end

    assign gnt_onehot = NUM_REQ'(1) << gnt_q;

    // Next state and next registered outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        tmo_nxt   = '0;
        rdata_nxt = rdata_q;
        rcrc_nxt  = rcrc_q;
        busy_nxt  = busy_q;
        gnt_nxt   = gnt_q;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
`ifdef HV_RAC_ARB_RR_EN
        ptr_nxt   = ptr;
`endif
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    gnt_nxt   = win_id;
                    rd_nxt    = ~sel_wr;
                    wr_nxt    = sel_wr;
                    addr_nxt  = sel_addr;
                    wdata_nxt = sel_wdata;
`ifdef HV_RAC_ARB_RR_EN
                    ptr_nxt   = win_id;
`endif
                end
            end
            ST_WAIT: begin
                // A real ack beats a timeout decided in the same cycle
                if (bus.i_rac_ack) begin
                    state_nxt = ST_RESP;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rdata_nxt = bus.i_rac_rdata;
                    rcrc_nxt  = bus.i_rac_crc;
                    ack_nxt   = gnt_onehot;
                end else if (cnt == TMO_CNT_W'(ACK_TMO_TH - 1)) begin
                    state_nxt = ST_RESP;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rdata_nxt = '0;
                    rcrc_nxt  = '0;
                    ack_nxt   = gnt_onehot;
                    tmo_nxt   = gnt_onehot;
                end else begin
                    cnt_nxt   = cnt + TMO_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
                rdata_nxt = '0;
                rcrc_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
                rd_nxt    = 1'b0;
                wr_nxt    = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ack_q   <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            rcrc_q  <= '0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef HV_RAC_ARB_RR_EN
            ptr     <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ack_q   <= ack_nxt;
            tmo_q   <= tmo_nxt;
            rdata_q <= rdata_nxt;
            rcrc_q  <= rcrc_nxt;
            busy_q  <= busy_nxt;
            gnt_q   <= gnt_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
`ifdef HV_RAC_ARB_RR_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_tmo_err    = tmo_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.o_rcrc       = rcrc_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_gnt_id     = gnt_q;
    assign bus.o_rac_rd_req = rd_q;
    assign bus.o_rac_wr_req = wr_q;
    assign bus.o_rac_addr   = addr_q;
    assign bus.o_rac_wdata  = wdata_q;
endmodule

// File: tb/tb_hv_rac_arb.sv
// tb_hv_rac_arb: directed bench for hv_rac_arb with a response scoreboard.
`timescale 1ns/1ps
module tb_hv_rac_arb;
    typedef struct {
        logic [2:0] ack;
        logic [2:0] tmo;
        logic [7:0] rdata;
        logic [7:0] rcrc;
    } rsp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    hv_rac_arb_if #(.NUM_REQ(3), .REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) bus ();

    hv_rac_arb dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, score any response pulse
    task automatic tick();
        rsp_t e;
        @(posedge clk);
        #1;
        chk("tmo_without_ack", 32'(bus.o_tmo_err & ~bus.o_ack), 32'h0);
        if (bus.o_ack !== 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 32'(bus.o_ack), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_ack",   32'(bus.o_ack),     32'(e.ack));
                chk("rsp_tmo",   32'(bus.o_tmo_err), 32'(e.tmo));
                chk("rsp_rdata", 32'(bus.o_rdata),   32'(e.rdata));
                chk("rsp_rcrc",  32'(bus.o_rcrc),    32'(e.rcrc));
            end
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ack"},   32'(bus.o_ack),        32'h0);
        chk({pfx, "_tmo"},   32'(bus.o_tmo_err),    32'h0);
        chk({pfx, "_rdata"}, 32'(bus.o_rdata),      32'h0);
        chk({pfx, "_rcrc"},  32'(bus.o_rcrc),       32'h0);
        chk({pfx, "_busy"},  32'(bus.o_busy),       32'h0);
        chk({pfx, "_gnt"},   32'(bus.o_gnt_id),     32'h0);
        chk({pfx, "_rd"},    32'(bus.o_rac_rd_req), 32'h0);
        chk({pfx, "_wr"},    32'(bus.o_rac_wr_req), 32'h0);
        chk({pfx, "_addr"},  32'(bus.o_rac_addr),   32'h0);
        chk({pfx, "_wdata"}, 32'(bus.o_rac_wdata),  32'h0);
    endtask

    task automatic do_reset(input string pfx);
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero(pfx);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int   order[4];
        int   n_gnt;
        bit   reraise;
        logic [2:0] req_pat;
        logic got;

        rst = 1'b1;
        bus.i_req = '0;
        bus.i_wr = '0;
        bus.i_addr = '0;
        bus.i_wdata = '0;
        bus.i_rac_ack = 1'b0;
        bus.i_rac_rdata = '0;
        bus.i_rac_crc = '0;

        do_reset("por");

        // 1: wdg read, latched address, ack after three WAIT cycles
        bus.i_req  = 3'b010;
        bus.i_wr   = 3'b000;
        bus.i_addr = {7'h00, 7'h5B, 7'h00};
        tick();
        chk("t1_rd_req", 32'(bus.o_rac_rd_req), 32'h1);
        chk("t1_wr_req", 32'(bus.o_rac_wr_req), 32'h0);
        chk("t1_addr",   32'(bus.o_rac_addr),   32'h5B);
        chk("t1_busy",   32'(bus.o_busy),       32'h1);
        chk("t1_gnt",    32'(bus.o_gnt_id),     32'h1);
        bus.i_req  = 3'b000;
        bus.i_addr = {7'h7F, 7'h7F, 7'h7F};
        tick();
        chk("t1_addr_held", 32'(bus.o_rac_addr),   32'h5B);
        chk("t1_req_held",  32'(bus.o_rac_rd_req), 32'h1);
        tick();
        bus.i_rac_ack   = 1'b1;
        bus.i_rac_rdata = 8'hA5;
        bus.i_rac_crc   = 8'h3C;
        exp_q.push_back('{ack: 3'b010, tmo: 3'b000, rdata: 8'hA5, rcrc: 8'h3C});
        tick();
        bus.i_rac_ack = 1'b0;
        chk("t1_rd_req_clr", 32'(bus.o_rac_rd_req), 32'h0);
        chk("t1_busy_resp",  32'(bus.o_busy),       32'h1);
        tick();
        chk("t1_ack_one_cycle", 32'(bus.o_ack),   32'h0);
        chk("t1_busy_low",      32'(bus.o_busy),  32'h0);
        chk("t1_rdata_clr",     32'(bus.o_rdata), 32'h0);
        tick();

        // 2: owt write
        bus.i_req   = 3'b001;
        bus.i_wr    = 3'b001;
        bus.i_addr  = {7'h00, 7'h00, 7'h09};
        bus.i_wdata = {8'h00, 8'h00, 8'h5A};
        tick();
        chk("t2_wr_req", 32'(bus.o_rac_wr_req), 32'h1);
        chk("t2_rd_req", 32'(bus.o_rac_rd_req), 32'h0);
        chk("t2_wdata",  32'(bus.o_rac_wdata),  32'h5A);
        chk("t2_addr",   32'(bus.o_rac_addr),   32'h09);
        chk("t2_gnt",    32'(bus.o_gnt_id),     32'h0);
        bus.i_req = 3'b000;
        bus.i_wr  = 3'b000;
        tick();
        bus.i_rac_ack   = 1'b1;
        bus.i_rac_rdata = 8'h77;
        bus.i_rac_crc   = 8'h11;
        exp_q.push_back('{ack: 3'b001, tmo: 3'b000, rdata: 8'h77, rcrc: 8'h11});
        tick();
        bus.i_rac_ack = 1'b0;
        chk("t2_wr_req_clr", 32'(bus.o_rac_wr_req), 32'h0);
        tick();
        tick();

        // 3: contention, starting from a fresh arbitration pointer
        do_reset("rst3");
`ifdef HV_RAC_ARB_RR_EN
        req_pat = 3'b101;
        order   = '{0, 2, 0, 2};
        n_gnt   = 4;
        reraise = 1'b1;
`else
        req_pat = 3'b111;
        order   = '{0, 1, 2, 0};
        n_gnt   = 3;
        reraise = 1'b0;
`endif
        bus.i_req  = req_pat;
        bus.i_wr   = 3'b000;
        bus.i_addr = {7'h23, 7'h22, 7'h21};
        for (int n = 0; n < n_gnt; n++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && got !== 1'b1; w++) begin
                tick();
                got = bus.o_rac_rd_req;
            end
            chk("t3_grant_seen", 32'(got),            32'h1);
            chk("t3_gnt_id",     32'(bus.o_gnt_id),   32'(order[n]));
            chk("t3_addr",       32'(bus.o_rac_addr), 32'h21 + 32'(order[n]));
            tick();
            bus.i_rac_ack   = 1'b1;
            bus.i_rac_rdata = 8'(32'h10 + n);
            bus.i_rac_crc   = 8'(32'hC0 + n);
            exp_q.push_back('{ack: 3'(1 << order[n]), tmo: 3'b000,
                              rdata: 8'(32'h10 + n), rcrc: 8'(32'hC0 + n)});
            tick();
            bus.i_rac_ack = 1'b0;
            bus.i_req = bus.i_req & ~3'(1 << order[n]);
            if (reraise && n < n_gnt - 1) begin
                tick();
                bus.i_req = req_pat;
            end
        end
        bus.i_req = 3'b000;
        tick();
        tick();

        // 4: bist read never acked, timeout after the sixteenth WAIT cycle
        bus.i_req  = 3'b100;
        bus.i_addr = {7'h33, 7'h00, 7'h00};
        tick();
        chk("t4_rd_req", 32'(bus.o_rac_rd_req), 32'h1);
        chk("t4_gnt",    32'(bus.o_gnt_id),     32'h2);
        bus.i_req       = 3'b000;
        bus.i_rac_rdata = 8'hFF;
        bus.i_rac_crc   = 8'hFF;
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("t4_req_held", 32'(bus.o_rac_rd_req), 32'h1);
        end
        exp_q.push_back('{ack: 3'b100, tmo: 3'b100, rdata: 8'h00, rcrc: 8'h00});
        tick();
        chk("t4_rd_req_clr", 32'(bus.o_rac_rd_req), 32'h0);
        tick();
        chk("t4_ack_one_cycle", 32'(bus.o_ack),     32'h0);
        chk("t4_tmo_one_cycle", 32'(bus.o_tmo_err), 32'h0);
        chk("t4_busy_low",      32'(bus.o_busy),    32'h0);
        tick();

        // 5: ack on the very cycle the timeout would fire
        bus.i_req  = 3'b010;
        bus.i_addr = {7'h00, 7'h44, 7'h00};
        tick();
        bus.i_req = 3'b000;
        for (int i = 2; i <= 16; i++) tick();
        chk("t5_req_held_c16", 32'(bus.o_rac_rd_req), 32'h1);
        bus.i_rac_ack   = 1'b1;
        bus.i_rac_rdata = 8'hC3;
        bus.i_rac_crc   = 8'h5E;
        exp_q.push_back('{ack: 3'b010, tmo: 3'b000, rdata: 8'hC3, rcrc: 8'h5E});
        tick();
        bus.i_rac_ack = 1'b0;
        tick();
        tick();

        // 6: reset mid-WAIT, then a stale ack
        bus.i_req  = 3'b001;
        bus.i_addr = {7'h00, 7'h00, 7'h12};
        tick();
        chk("t6_rd_req", 32'(bus.o_rac_rd_req), 32'h1);
        bus.i_req = 3'b000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        rst = 1'b0;
        tick();
        bus.i_rac_ack   = 1'b1;
        bus.i_rac_rdata = 8'h99;
        bus.i_rac_crc   = 8'h66;
        tick();
        bus.i_rac_ack = 1'b0;
        tick();
        chk_all_zero("t6_stale");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
